// File: rtl/counter_window_arbiter.sv
// -----------------------------------------------------------------------------
// counter_window_arbiter
//
// Shares one external up-counter between two requesters. Each requester asks
// for a counting window of a given length. Windows are granted round-robin.
// The counter's enable is driven for exactly that many cycles, and the measured
// count is returned. The count is the modular difference of two counter
// snapshots, so the counter is never cleared by this block.
//
// Ports
//   clk         in   1      rising-edge clock
//   reset       in   1      asynchronous, active-low reset
//   req         in   2      per-requester window request (level, sampled in IDLE)
//   len0/len1   in   LEN_W  window length per requester (sampled in GRANT)
//   gnt         out  2      one-hot grant pulse
//   done        out  2      one-hot completion pulse
//   cnt_o       out  WIDTH  measured count, valid while done != 0, else 0
//   busy        out  1      high in every state except IDLE
//   cnt_ena     out  1      counter enable
//   cnt_result  in   WIDTH  counter value
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | wait for a request, pick the round-robin winner
// GRANT | pulse gnt, latch window length and the start snapshot
// RUN   | counter enabled, one cycle per remaining window count
// WAIT  | counter disabled and settling, compute the modular difference
// DONE  | pulse done with the measured count, update round-robin marker
// -----------------------------------------------------------------------------
module counter_window_arbiter #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req,
    input  logic [LEN_W-1:0] len0,
    input  logic [LEN_W-1:0] len1,
    output logic [1:0]       gnt,
    output logic [1:0]       done,
    output logic [WIDTH-1:0] cnt_o,
    output logic             busy,
    output logic             cnt_ena,
    input  logic [WIDTH-1:0] cnt_result
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_GRANT = 3'd1,
        S_RUN   = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t           r_state;
    logic             r_owner;
    logic             r_last;
    logic [LEN_W-1:0] r_remain;
    logic [WIDTH-1:0] r_start;
    logic [1:0]       r_gnt;
    logic [1:0]       r_done;
    logic [WIDTH-1:0] r_cnt_o;
    logic             r_busy;
    logic             r_cnt_ena;

    logic             w_winner;
    logic [LEN_W-1:0] w_len_owner;
    logic [WIDTH-1:0] w_diff;
    logic [1:0]       w_owner_oh;

    // On a tie the requester not served last wins.
    assign w_winner    = (req == 2'b11) ? ~r_last : req[1];
    assign w_len_owner = r_owner ? len1 : len0;
    // Modular subtraction absorbs counter wrap-around.
    assign w_diff      = cnt_result - r_start;
    assign w_owner_oh  = r_owner ? 2'b10 : 2'b01;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_owner   <= 1'b0;
            r_last    <= 1'b1;
            r_remain  <= '0;
            r_start   <= '0;
            r_gnt     <= 2'b00;
            r_done    <= 2'b00;
            r_cnt_o   <= '0;
            r_busy    <= 1'b0;
            r_cnt_ena <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req != 2'b00) begin
                        r_owner <= w_winner;
                        r_gnt   <= w_winner ? 2'b10 : 2'b01;
                        r_busy  <= 1'b1;
                        r_state <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    r_gnt    <= 2'b00;
                    r_remain <= w_len_owner;
                    // Counter is idle here, so its value is a stable snapshot.
                    r_start  <= cnt_result;
                    if (w_len_owner != '0) begin
                        r_cnt_ena <= 1'b1;
                        r_state   <= S_RUN;
                    end else begin
                        r_state <= S_WAIT;
                    end
                end
                S_RUN: begin
                    r_remain <= r_remain - LEN_W'(1);
                    if (r_remain == LEN_W'(1)) begin
                        r_cnt_ena <= 1'b0;
                        r_state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // r_cnt_o doubles as the diff register; it is only
                    // visible during DONE and cleared on the way out.
                    r_cnt_o <= w_diff;
                    r_done  <= w_owner_oh;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_done  <= 2'b00;
                    r_cnt_o <= '0;
                    r_last  <= r_owner;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_gnt     <= 2'b00;
                    r_done    <= 2'b00;
                    r_cnt_o   <= '0;
                    r_busy    <= 1'b0;
                    r_cnt_ena <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    assign gnt     = r_gnt;
    assign done    = r_done;
    assign cnt_o   = r_cnt_o;
    assign busy    = r_busy;
    assign cnt_ena = r_cnt_ena;

endmodule

// File: tb/tb_counter_window_arbiter.sv
module tb_counter_window_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] req;
    logic [7:0] len0;
    logic [7:0] len1;
    logic [1:0] gnt;
    logic [1:0] done;
    logic [7:0] cnt_o;
    logic       busy;
    logic       cnt_ena;
    logic [7:0] cnt_result;

    logic       cnt_load = 1'b0;
    logic [7:0] cnt_load_val = 8'd0;
    logic [7:0] cnt_val = 8'd0;

    int         errors = 0;
    int         checks = 0;
    bit         model_last;
    logic [7:0] exp_cnt;

    logic [13:0] obs;
    assign obs = {gnt, done, cnt_o, busy, cnt_ena};

    always #5 clk = ~clk;

    // Shared counter: plain 8-bit up-counter with enable, plus a bench-only
    // preload to set up wrap-around cases. It is never reset by the DUT.
    always_ff @(posedge clk) begin
        if (cnt_load)
            cnt_val <= cnt_load_val;
        else if (cnt_ena)
            cnt_val <= cnt_val + 8'd1;
    end
    assign cnt_result = cnt_val;

    counter_window_arbiter #(.WIDTH(8), .LEN_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .len0       (len0),
        .len1       (len1),
        .gnt        (gnt),
        .done       (done),
        .cnt_o      (cnt_o),
        .busy       (busy),
        .cnt_ena    (cnt_ena),
        .cnt_result (cnt_result)
    );

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    task automatic load_counter(input logic [7:0] v);
        cnt_load     = 1'b1;
        cnt_load_val = v;
        @(negedge clk);
        cnt_load = 1'b0;
        exp_cnt  = v;
    endtask

    // Runs one window from the IDLE negedge using the current req/len0/len1.
    // Expected per-cycle outputs come from the timing rules: gnt at c+1,
    // cnt_ena over c+2..c+1+L, done with count L at c+3+L, busy throughout.
    // abort_at > 0 pulls reset low at that cycle offset instead of completing.
    task automatic run_window(input int abort_at, input string name);
        int         w;
        int         len;
        logic [1:0] oh;
        logic [7:0] start;
        logic [1:0] eg;
        logic [1:0] ed;
        logic [7:0] eco;
        logic       ee;
        if (req == 2'b11) w = model_last ? 0 : 1;
        else              w = req[1] ? 1 : 0;
        len   = (w == 1) ? int'(len1) : int'(len0);
        oh    = (w == 1) ? 2'b10 : 2'b01;
        start = exp_cnt;
        for (int k = 1; k <= len + 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            eg  = (k == 1) ? oh : 2'b00;
            ed  = (k == len + 3) ? oh : 2'b00;
            eco = (k == len + 3) ? 8'(len) : 8'd0;
            ee  = (k >= 2 && k <= len + 1);
            chk(name, 32'(obs), 32'({eg, ed, eco, 1'b1, ee}));
            if (k == abort_at) begin
                reset = 1'b0;
                #1;
                chk({name, "_rst_now"}, 32'(obs), 32'd0);
                exp_cnt = start + 8'(k - 2);
                req     = 2'b00;
                for (int h = 0; h < 3; h++) begin
                    @(negedge clk);
                    chk({name, "_rst_hold"}, 32'({obs, cnt_val}), 32'({14'd0, exp_cnt}));
                end
                reset      = 1'b1;
                model_last = 1'b1;
                @(negedge clk);
                chk({name, "_after_rst"}, 32'({obs, cnt_val}), 32'({14'd0, exp_cnt}));
                return;
            end
        end
        req[w]     = 1'b0;
        model_last = (w == 1);
        exp_cnt    = start + 8'(len);
        chk({name, "_counter"}, 32'(cnt_val), 32'(exp_cnt));
        @(posedge clk);
        @(negedge clk);
        chk({name, "_idle"}, 32'(obs), 32'd0);
    endtask

    initial begin
        reset      = 1'b0;
        req        = 2'b00;
        len0       = 8'd0;
        len1       = 8'd0;
        model_last = 1'b1;
        exp_cnt    = 8'd0;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset_outputs", 32'(obs), 32'd0);
        end
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_no_req", 32'(obs), 32'd0);
        end

        load_counter(8'd0);

        // Tie: requester 0 first, then 1, then 0 again on a fresh tie.
        req  = 2'b11;
        len0 = 8'd3;
        len1 = 8'd4;
        run_window(0, "tie_first");
        run_window(0, "tie_second");
        req = 2'b11;
        run_window(0, "tie_rearm");
        run_window(0, "tie_rearm_other");

        req  = 2'b01;
        len0 = 8'd5;
        run_window(0, "single");

        load_counter(8'd250);
        req  = 2'b10;
        len1 = 8'd10;
        run_window(0, "wrap");
        chk("wrap_counter_value", 32'(cnt_val), 32'd4);

        req  = 2'b01;
        len0 = 8'd0;
        run_window(0, "zero_len");

        req  = 2'b01;
        len0 = 8'd20;
        run_window(7, "midrun");

        req  = 2'b01;
        len0 = 8'd5;
        run_window(0, "single_after_rst");

        for (int n = 0; n < 30; n++) begin
            if (req == 2'b00 && $urandom_range(0, 3) == 0)
                load_counter(8'($urandom_range(0, 255)));
            req  = req | 2'($urandom_range(1, 3));
            len0 = 8'($urandom_range(0, 15));
            len1 = 8'($urandom_range(0, 15));
            run_window(0, "random");
        end
        for (int n = 0; n < 2; n++)
            if (req != 2'b00) run_window(0, "drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/counter_window_arbiter.md
# counter_window_arbiter

Arbiter and sequencer that shares one free-running-capable `counter` instance (8-bit, `clk`/`reset`/`ena`/`result`) between two requesters. Each requester asks for a counting window of a given length. The block grants windows round-robin, drives the counter's `ena` for exactly that many cycles, and returns the measured count. The count is computed as the difference of counter snapshots, so the counter itself needs no clear input and is never reset by this block.

## Interface

Parameters:
- `WIDTH`, default 8: counter width; width of `cnt_result` and `cnt_o`.
- `LEN_W`, default 8: width of window-length inputs; must satisfy `LEN_W <= WIDTH`.

Ports:
- `clk`  input  1: single clock, rising edge.
- `reset`  input  1: asynchronous, active-low reset.
- `req`  input  2: per-requester window request, level; sampled only in IDLE.
- `len0`  input  LEN_W: requester 0 window length, sampled in GRANT.
- `len1`  input  LEN_W: requester 1 window length, sampled in GRANT.
- `gnt`  output  2: one-hot grant pulse, one cycle.
- `done`  output  2: one-hot completion pulse, one cycle.
- `cnt_o`  output  WIDTH: measured count; valid only while `done` is nonzero.
- `busy`  output  1: high in every state except IDLE.
- `cnt_ena`  output  1: drives the counter's `ena`.
- `cnt_result`  input  WIDTH: the counter's `result`.

## Operation

States are IDLE, GRANT, RUN, WAIT and DONE. Every output is registered or decoded directly from registered state.
- **IDLE**
  - If `req` is nonzero, pick the winner.
    - Only one requester asserting `req`: that requester wins.
    - Both asserting `req`: the requester not marked by `last` wins.
  - Record the winner in `owner`, then go to GRANT.
- **GRANT** (1 cycle)
  - `gnt[owner]` = 1.
  - Latch `len_owner` into `remain`.
  - Latch `cnt_result` into `start` (counter is idle, so `cnt_result` is stable).
  - Next state is RUN if the latched length is nonzero, otherwise WAIT.
- **RUN** (`len` cycles)
  - `cnt_ena` = 1 and `remain` decrements each cycle.
  - Leave for WAIT on the cycle in which `remain` == 1.
- **WAIT** (1 cycle)
  - `cnt_ena` = 0. Counter settles.
  - Register `diff` = (`cnt_result` − `start`) mod 2^WIDTH. Counter wrap-around is handled by the modular subtraction.
- **DONE** (1 cycle)
  - `done[owner]` = 1 and `cnt_o` = `diff`.
  - Set `last` = `owner`, then return to IDLE.
- **Outside DONE:** `cnt_o` holds 0.
- **Request handling**
  - `req` is ignored outside IDLE. Dropping `req` after a grant does not abort the window.
  - A `req` still high in IDLE starts a new window, so holding `req` gives back-to-back windows.
  - Requesters should deassert `req` on `done`.
- **Reset (`reset` = 0)**, asynchronous, any state:
  - state goes to IDLE;
  - `gnt`, `done`, `cnt_o`, `busy` and `cnt_ena` go to 0;
  - `last` = 1, so requester 0 wins the first tie;
  - `remain`, `start` and `diff` go to 0.
- **Reset mid-window:** `cnt_ena` drops immediately, no `done` is issued, and the counter value is left as is.

## Timing

- Reference point: `req` high in IDLE at cycle c.
  - GRANT at c+1.
  - RUN at c+2 … c+1+len.
  - WAIT at c+2+len.
  - DONE at c+3+len.
- `len` = 0: GRANT c+1, WAIT c+2, DONE c+3, and `cnt_ena` is never asserted.
- Minimum spacing between windows is one IDLE cycle after DONE, so a window of length L repeats every L+4 cycles.
- `cnt_ena` is high for exactly `len` consecutive cycles per window.
- The counter's one-cycle update latency is absorbed by WAIT.
- `busy` rises in GRANT and falls when returning to IDLE.

## Test plan

- **Reset values:** hold `reset` = 0 for 3 cycles, then release.
  - While `reset` = 0: all outputs are 0.
  - After release, with `req` = 0: state stays IDLE and `cnt_ena` stays 0.
- **Single request:** `req` = 01, `len0` = 5, counter starting at 0.
  - `gnt` = 01 at c+1.
  - `cnt_ena` high for exactly 5 cycles.
  - `done` = 01 at c+8 with `cnt_o` = 5.
- **Simultaneous requests:** `req` = 11, `len0` = 3, `len1` = 4, held high until their own `done`.
  - Requester 0 is served first: `done[0]` with `cnt_o` = 3.
  - Requester 1 is served next: `done[1]` with `cnt_o` = 4.
  - Then re-raise both requests: requester 0 is granted, because `last` = 1.
- **Wrap-around:** preload the counter to 250, then `len1` = 10 → `cnt_o` = 10 while `cnt_result` reads 4.
- **Zero length:** `len0` = 0.
  - `cnt_ena` is never asserted.
  - `done[0]` arrives at c+3 with `cnt_o` = 0.
- **Reset mid-RUN:** `len0` = 20, assert `reset` = 0 on the 6th RUN cycle.
  - `cnt_ena` goes to 0 immediately and no `done` is issued.
  - After release, a new request behaves as in the single-request case.
